// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and default geometry for the systolic edge feeder.
package systolic_skew_feeder_pkg;

  localparam int DEF_DATA_BITS  = 16;
  localparam int DEF_ARRAY_SIZE = 8;
  localparam int DEF_K_BITS     = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/systolic_skew_feeder_delay.sv
// Fixed-depth registered shift line; one instance per lane per operand builds the skew triangle.
module skew_delay_line #(
  parameter int DEPTH     = 1,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout
);

  logic [DATA_BITS-1:0] stage_r [DEPTH];

  // Shift chain, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        stage_r[j] <= '0;
      end
    end else begin
      stage_r[0] <= din;
      for (int j = 1; j < DEPTH; j++) begin
        stage_r[j] <= stage_r[j-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Tile job sequencer: clears the array, streams K vector pairs through a triangular
// skew, drains the skew with zeros and reports completion.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int K_BITS     = DEF_K_BITS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [K_BITS-1:0]               k_len,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ARRAY_SIZE*DATA_BITS-1:0] a_vec_flat,
  input  logic [ARRAY_SIZE*DATA_BITS-1:0] b_vec_flat,
  output logic [ARRAY_SIZE*DATA_BITS-1:0] a_inputs_flat,
  output logic [ARRAY_SIZE*DATA_BITS-1:0] b_inputs_flat,
  output logic                            clear_acc,
  output logic                            compute_enable,
  output logic                            busy,
  output logic                            done
);

  // Drain must flush the deepest lane and let the far corner PE see it.
  localparam int                 DRAIN_W    = $clog2(2 * ARRAY_SIZE);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2 * ARRAY_SIZE - 3);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [K_BITS-1:0]  K_ONE      = K_BITS'(1);

  feeder_state_t       state_r;
  logic [K_BITS-1:0]   k_len_r;
  logic [K_BITS-1:0]   xfer_cnt_r;
  logic [DRAIN_W-1:0]  drain_cnt_r;
  logic                in_ready_r;
  logic                clear_acc_r;
  logic                compute_enable_r;
  logic                busy_r;
  logic                done_r;
  logic                xfer_s;

  assign xfer_s         = in_valid & in_ready_r;
  assign in_ready       = in_ready_r;
  assign clear_acc      = clear_acc_r;
  assign compute_enable = compute_enable_r;
  assign busy           = busy_r;
  assign done           = done_r;

  // Job sequencer with registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      k_len_r          <= '0;
      xfer_cnt_r       <= '0;
      drain_cnt_r      <= '0;
      in_ready_r       <= 1'b0;
      clear_acc_r      <= 1'b0;
      compute_enable_r <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            k_len_r     <= k_len;
            xfer_cnt_r  <= '0;
            clear_acc_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          clear_acc_r <= 1'b0;
          if (k_len_r != '0) begin
            in_ready_r       <= 1'b1;
            compute_enable_r <= 1'b1;
            state_r          <= ST_STREAM;
          end else begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_STREAM: begin
          if (xfer_s) begin
            xfer_cnt_r <= xfer_cnt_r + K_ONE;
            if (xfer_cnt_r == k_len_r - K_ONE) begin
              in_ready_r  <= 1'b0;
              drain_cnt_r <= '0;
              state_r     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // compute_enable stays high into DONE so the last skewed element is consumed.
          if (drain_cnt_r == DRAIN_LAST) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            drain_cnt_r <= drain_cnt_r + DRAIN_ONE;
          end
        end
        ST_DONE: begin
          done_r           <= 1'b0;
          busy_r           <= 1'b0;
          compute_enable_r <= 1'b0;
          state_r          <= ST_IDLE;
        end
        default: begin
          in_ready_r       <= 1'b0;
          clear_acc_r      <= 1'b0;
          compute_enable_r <= 1'b0;
          busy_r           <= 1'b0;
          done_r           <= 1'b0;
          state_r          <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [DATA_BITS-1:0] a_din_s;
    logic [DATA_BITS-1:0] b_din_s;

    // Non-transfer cycles inject a zero bubble so skew alignment is kept.
    always_comb begin
      if (xfer_s) begin
        a_din_s = a_vec_flat[i*DATA_BITS +: DATA_BITS];
        b_din_s = b_vec_flat[i*DATA_BITS +: DATA_BITS];
      end else begin
        a_din_s = '0;
        b_din_s = '0;
      end
    end

    skew_delay_line #(.DEPTH(i + 1), .DATA_BITS(DATA_BITS)) u_a_skew (
      .clk   (clk),
      .reset (reset),
      .din   (a_din_s),
      .dout  (a_inputs_flat[i*DATA_BITS +: DATA_BITS])
    );

    skew_delay_line #(.DEPTH(i + 1), .DATA_BITS(DATA_BITS)) u_b_skew (
      .clk   (clk),
      .reset (reset),
      .din   (b_din_s),
      .dout  (b_inputs_flat[i*DATA_BITS +: DATA_BITS])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: every cycle compares control outputs and
// both skewed edge feeds against a transfer-history model.
module tb_systolic_skew_feeder;

  localparam int DB = 16;
  localparam int N  = 8;
  localparam int KB = 8;
  localparam int W  = N * DB;
  localparam int HIST = 2048;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [KB-1:0] k_len;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_vec_flat;
  logic [W-1:0]  b_vec_flat;
  logic [W-1:0]  a_inputs_flat;
  logic [W-1:0]  b_inputs_flat;
  logic          clear_acc;
  logic          compute_enable;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [W-1:0] hist_a [HIST];
  logic [W-1:0] hist_b [HIST];

  systolic_skew_feeder #(.DATA_BITS(DB), .ARRAY_SIZE(N), .K_BITS(KB)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .k_len          (k_len),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a_vec_flat     (a_vec_flat),
    .b_vec_flat     (b_vec_flat),
    .a_inputs_flat  (a_inputs_flat),
    .b_inputs_flat  (b_inputs_flat),
    .clear_acc      (clear_acc),
    .compute_enable (compute_enable),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_flat(input bit is_b);
    logic [W-1:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < N; i++) begin
      idx = cyc - 1 - i;
      if (idx >= 0) begin
        r[i*DB +: DB] = is_b ? hist_b[idx][i*DB +: DB] : hist_a[idx][i*DB +: DB];
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] make_vec(input logic [15:0] base, input int n);
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[i*DB +: DB] = base + 16'(n * 16) + 16'(i);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] garbage();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_hist();
    for (int i = 0; i < HIST; i++) begin
      hist_a[i] = '0;
      hist_b[i] = '0;
    end
  endtask

  // Check one cycle of outputs, record any transfer into the model, advance a cycle.
  task automatic tick(input bit e_ready, input bit e_clear, input bit e_ce,
                      input bit e_busy, input bit e_done);
    chk("in_ready", W'(in_ready), W'(e_ready));
    chk("clear_acc", W'(clear_acc), W'(e_clear));
    chk("compute_enable", W'(compute_enable), W'(e_ce));
    chk("busy", W'(busy), W'(e_busy));
    chk("done", W'(done), W'(e_done));
    chk("a_inputs", a_inputs_flat, exp_flat(1'b0));
    chk("b_inputs", b_inputs_flat, exp_flat(1'b1));
    if (in_valid && e_ready && cyc < HIST) begin
      hist_a[cyc] = a_vec_flat;
      hist_b[cyc] = b_vec_flat;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_job(input int k, input int gap, input logic [15:0] a_base,
                         input logic [15:0] b_base, input bit poke_drain);
    int n;
    start = 1'b1;
    k_len = KB'(k);
    in_valid = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    k_len = 8'd2;
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (n < k) begin
      in_valid   = 1'b1;
      a_vec_flat = make_vec(a_base, n);
      b_vec_flat = make_vec(b_base, n);
      tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      n++;
      if (n < k) begin
        for (int g = 0; g < gap; g++) begin
          in_valid   = 1'b0;
          a_vec_flat = garbage();
          b_vec_flat = garbage();
          tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        end
      end
    end
    if (k > 0) begin
      for (int d = 0; d < 2 * N - 2; d++) begin
        in_valid   = 1'b1;
        a_vec_flat = garbage();
        b_vec_flat = garbage();
        start      = (poke_drain && d == 3) ? 1'b1 : 1'b0;
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    tick(1'b0, 1'b0, (k > 0) ? 1'b1 : 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    k_len      = '0;
    in_valid   = 1'b0;
    a_vec_flat = '0;
    b_vec_flat = '0;
    clear_hist();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;

    // Single-vector job with lane-indexed values.
    run_job(1, 0, 16'h1000, 16'h2000, 1'b0);
    // Back-to-back stream of four.
    run_job(4, 0, 16'h3000, 16'h4000, 1'b0);
    // Two-cycle bubbles between transfers.
    run_job(3, 2, 16'h5000, 16'h6000, 1'b0);
    // Empty job.
    run_job(0, 0, 16'h7000, 16'h7100, 1'b0);

    // Abort a five-vector job after two transfers.
    start = 1'b1;
    k_len = 8'd5;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 2; n++) begin
      in_valid   = 1'b1;
      a_vec_flat = make_vec(16'h8000, n);
      b_vec_flat = make_vec(16'h9000, n);
      tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    clear_hist();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    run_job(3, 0, 16'hA000, 16'hB000, 1'b0);

    // Start pulsed mid-drain must be ignored.
    run_job(2, 0, 16'hC000, 16'hD000, 1'b1);
    // Maximum reduction length must not wrap the transfer counter.
    run_job(255, 0, 16'hE000, 16'hF000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 16, Q1.15 element width.
REQ-002 The block SHALL have parameter ARRAY_SIZE, default 8, lanes per operand (array edge length).
REQ-003 The block SHALL have parameter K_BITS, default 8, width of the reduction-length field.
REQ-004 The block SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 The block SHALL have port start, input, 1, request for one tile job; sampled only in IDLE.
REQ-007 The block SHALL have port k_len, input, K_BITS, number of operand vectors in the job; captured with start.
REQ-008 The block SHALL have port in_valid, input, 1, source has a vector pair on a_vec_flat/b_vec_flat.
REQ-009 The block SHALL have port in_ready, output, 1, block accepts a vector pair this cycle.
REQ-010 The block SHALL have port a_vec_flat, input, ARRAY_SIZE*DATA_BITS, A column vector; lane i at [i*DATA_BITS +: DATA_BITS].
REQ-011 The block SHALL have port b_vec_flat, input, ARRAY_SIZE*DATA_BITS, B row vector; same packing.
REQ-012 The block SHALL have port a_inputs_flat, output, ARRAY_SIZE*DATA_BITS, skewed A edge feed to the array cluster.
REQ-013 The block SHALL have port b_inputs_flat, output, ARRAY_SIZE*DATA_BITS, skewed B edge feed to the array cluster.
REQ-014 The block SHALL have port clear_acc, output, 1, accumulator clear for the cluster.
REQ-015 The block SHALL have port compute_enable, output, 1, MAC enable for the cluster.
REQ-016 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-017 The block SHALL have port done, output, 1, one-cycle pulse when the tile result is complete in the array.

Function
REQ-018 The FSM SHALL have states IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-019 IDLE with start=1 SHALL capture k_len and go to CLEAR; start while busy SHALL be ignored.
REQ-020 CLEAR SHALL last one cycle with clear_acc=1, then go to STREAM if captured k_len>0, else DONE.
REQ-021 In STREAM, in_ready SHALL be 1; a transfer occurs when in_valid and in_ready are both 1 in the same cycle.
REQ-022 STREAM SHALL count transfers and go to DRAIN in the cycle after the k_len-th transfer.
REQ-023 A STREAM cycle without a transfer SHALL inject zero on all lanes of both operands (bubble), preserving skew alignment.
REQ-024 Lane i of a transferred vector (A and B alike) SHALL appear on the outputs exactly 1+i cycles after the transfer cycle (registered, triangular skew).
REQ-025 DRAIN SHALL last exactly 2*ARRAY_SIZE-2 cycles, shifting zeros in, then go to DONE.
REQ-026 compute_enable SHALL be 1 in STREAM, in DRAIN, and for one cycle after DRAIN, so every skewed element is consumed.
REQ-027 DONE SHALL assert done=1 for one cycle and return to IDLE; in_ready SHALL be 0 outside STREAM.
REQ-028 Outputs SHALL pass operands unmodified (no arithmetic); all lanes SHALL be zero whenever no valid data occupies that skew stage.
REQ-029 Transfer count SHALL be K_BITS wide; k_len=2^K_BITS-1 SHALL complete without wrap.

Reset
REQ-030 Reset SHALL force IDLE, clear all skew registers and the counter, and drive all outputs to 0.
REQ-031 Reset mid-job SHALL abandon it with no done pulse; the first post-reset cycle behaves as IDLE.

Structure
REQ-032 A shared package SHALL hold the FSM state typedef and defaults for DATA_BITS, ARRAY_SIZE and K_BITS.
REQ-033 One sub-module, skew_delay_line (parameter DEPTH, DATA_BITS-wide shift register, sync reset), SHALL be instantiated per lane per operand with DEPTH=1+i.

Verification
REQ-034 Reset then start, k_len=1, A lanes=0x1000+i, B lanes=0x2000+i -> clear_acc at cycle 1; lane i shows 0x1000+i/0x2000+i exactly 1+i cycles after transfer, zero otherwise.
REQ-035 k_len=4, in_valid held high -> 4 transfers in 4 cycles, DRAIN lasts 14 cycles, done pulses once, busy drops the following cycle.
REQ-036 k_len=3 with in_valid low for 2 cycles between transfers -> zero bubbles on all lanes; lane-7 output is the lane-0 sequence delayed by 7 cycles.
REQ-037 start with k_len=0 -> CLEAR one cycle, DONE next cycle, in_ready never 1, outputs stay 0.
REQ-038 Reset asserted during STREAM after 2 of 5 transfers -> next cycle all outputs 0, no done pulse; fresh start then completes normally.
REQ-039 start pulsed during DRAIN -> ignored; k_len capture unchanged; single done pulse.
